// File: rtl/c1541_sd_arb_pkg.sv
// c1541_pkg: shared FSM state type and constants for the SD block arbiter
package c1541_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;
  localparam int LBA_W = 32;
  localparam logic [23:0] TIMEOUT_DEF = 24'd16000000;
endpackage

// File: rtl/c1541_sd_arb_if.sv
// c1541_sd_arb_if: SD host block port shared by all drive track units
interface c1541_sd_arb_if;
  import c1541_pkg::*;
  logic [LBA_W-1:0] sd_lba;
  logic sd_rd;
  logic sd_wr;
  logic sd_ack;
  logic sd_buff_wr;
  logic [7:0] sd_buff_din;
  modport master (output sd_lba, sd_rd, sd_wr, sd_buff_din, input sd_ack, sd_buff_wr);
  modport slave (input sd_lba, sd_rd, sd_wr, sd_buff_din, output sd_ack, sd_buff_wr);
endinterface

// File: rtl/c1541_rr_pick.sv
// c1541_rr_pick: combinational round-robin picker, first pending index at or after ptr
module c1541_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            valid
);
  // scan from farthest to nearest so the index closest to ptr is the last one written
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      for (int i = 0; i < NREQ; i++)
        if (pending[i] && i == (int'(ptr) + k) % NREQ) idx = 2'(i);
  end
  assign valid = |pending;
endmodule

// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb: round-robin arbiter sharing one SD block port among NREQ track units
module c1541_sd_arb
  import c1541_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*32-1:0] req_lba,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    req_buff_wr,
  input  logic [NREQ*8-1:0]  req_buff_din,
  output logic [NREQ-1:0]    req_err,
  output logic               busy,
  c1541_sd_arb_if.master     sd
);
  state_t state;
  logic [1:0] ptr, grant, pick;
  logic pick_ok, wr_sel;
  logic [23:0] cnt;
  logic [LBA_W-1:0] lba_sel;
  logic [7:0] din_sel;
  logic [NREQ-1:0] err_mask;

  c1541_rr_pick #(.NREQ(NREQ)) u_pick (
    .pending (req_rd | req_wr),
    .ptr     (ptr),
    .idx     (pick),
    .valid   (pick_ok)
  );

  // steering: candidate LBA/direction from the pick, host handshake only to the grant during XFER
  always_comb begin
    lba_sel = '0;
    wr_sel = 1'b0;
    din_sel = '0;
    req_ack = '0;
    req_buff_wr = '0;
    err_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 2'(i)) begin
        lba_sel = req_lba[32*i +: 32];
        wr_sel = req_wr[i];
      end
      if (grant == 2'(i)) din_sel = req_buff_din[8*i +: 8];
      err_mask[i] = grant == 2'(i);
      req_ack[i] = state == XFER && grant == 2'(i) && sd.sd_ack;
      req_buff_wr[i] = state == XFER && grant == 2'(i) && sd.sd_buff_wr;
    end
  end

  assign sd.sd_buff_din = (state == IDLE) ? 8'h00 : din_sel;
  assign busy = state != IDLE;

  // arbitration FSM with latched grant, strobes, LBA and issue timeout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      sd.sd_rd <= 1'b0;
      sd.sd_wr <= 1'b0;
      sd.sd_lba <= '0;
      cnt <= '0;
      req_err <= '0;
    end else begin
      req_err <= '0;
      case (state)
        IDLE: if (pick_ok) begin
          grant <= pick;
          sd.sd_lba <= lba_sel;
          sd.sd_wr <= wr_sel;
          sd.sd_rd <= !wr_sel;
          cnt <= '0;
          state <= ISSUE;
        end
        ISSUE: if (sd.sd_ack) begin
          sd.sd_rd <= 1'b0;
          sd.sd_wr <= 1'b0;
          state <= XFER;
        end else if (cnt == TIMEOUT - 24'd1) begin
          sd.sd_rd <= 1'b0;
          sd.sd_wr <= 1'b0;
          req_err <= err_mask;
          state <= RELEASE;
        end else cnt <= cnt + 24'd1;
        XFER: if (!sd.sd_ack) state <= RELEASE;
        default: begin
          ptr <= (grant == 2'(NREQ - 1)) ? 2'd0 : grant + 2'd1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/c1541_sd_arb.md
C1541_SD_ARB -- requirements
Module: c1541_sd_arb

Interface
REQ-001 Parameter NREQ, default 2: number of drive track units sharing the one SD block port (1..4).
REQ-002 Parameter TIMEOUT, default 24'd16000000: clk cycles allowed from sd_rd/sd_wr assertion to sd_ack rise.
REQ-003 clk  in  1  sole clock; all SD-side and requester-side signals are synchronous to it.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_rd  in  NREQ  per-requester read request level; held until that requester's req_ack falls.
REQ-006 req_wr  in  NREQ  per-requester write request level; same holding rule.
REQ-007 req_lba  in  NREQ*32  per-requester LBA; slice i is bits [32i+31:32i].
REQ-008 req_ack  out  NREQ  sd_ack routed to the granted requester only.
REQ-009 req_buff_wr  out  NREQ  sd_buff_wr routed to the granted requester only.
REQ-010 req_buff_din  in  NREQ*8  per-requester buffer read data.
REQ-011 req_err  out  NREQ  one-cycle pulse to a requester whose transfer timed out.
REQ-012 sd_lba  out  32  LBA of the granted transfer.
REQ-013 sd_rd / sd_wr  out  1 each  SD read / write strobe.
REQ-014 sd_ack  in  1  SD host acknowledge; high for the whole sector transfer.
REQ-015 sd_buff_wr  in  1  SD host buffer write strobe.
REQ-016 sd_buff_din  out  8  granted requester's req_buff_din; 8'h00 when nothing is granted.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, XFER, RELEASE.
REQ-019 IDLE: a requester is pending when req_rd[i] or req_wr[i] is set. Round-robin search starts at pointer ptr. The first pending index becomes grant. Its LBA is latched into sd_lba. The direction is latched (wr wins when both are set). Next state is ISSUE.
REQ-020 Grant latency: sd_rd or sd_wr is asserted on the clk edge after the IDLE cycle that saw the request.
REQ-021 ISSUE: hold sd_rd/sd_wr. Go to XFER on the first cycle sd_ack=1. sd_rd/sd_wr deassert on that same edge.
REQ-022 XFER: req_ack[grant]=sd_ack and req_buff_wr[grant]=sd_buff_wr, both combinational. Go to RELEASE on the first cycle sd_ack=0.
REQ-023 RELEASE: one cycle. ptr <= (grant+1) mod NREQ. Next state is IDLE. This guarantees a requester can drop its request before it is re-arbitrated.
REQ-024 Ungranted requesters always see req_ack=0 and req_buff_wr=0.
REQ-025 Changes to req_lba or the request direction after grant are ignored until the next grant.
REQ-026 A 24-bit counter clears on entry to ISSUE and increments each cycle in ISSUE.
REQ-027 Timeout: when the counter reaches TIMEOUT-1, drop sd_rd/sd_wr, pulse req_err[grant] for one cycle, and go to RELEASE. The pointer rotates as normal.
REQ-028 sd_ack=1 seen while in IDLE or RELEASE is ignored and routed to no requester.
REQ-029 Requests rising while busy wait for IDLE. No request is lost while its level is held.
REQ-030 Fairness: with all NREQ requesters continuously pending, every requester is granted once per NREQ transfers.

Reset
REQ-031 On reset: state=IDLE, ptr=0, grant=0, sd_rd=0, sd_wr=0, sd_lba=0, counter=0, req_err=0, busy=0.
REQ-032 Reset mid-transfer: strobes fall immediately (asynchronously). req_ack and req_buff_wr become 0 because the state is IDLE.

Structure
REQ-033 Shared package c1541_pkg holds: the FSM state enum (2 bits), the sd_lba width constant (32), and the TIMEOUT default.
REQ-034 One sub-module, c1541_rr_pick: a combinational round-robin priority picker. Inputs: pending mask, ptr. Outputs: index, valid.
REQ-035 The top level holds the FSM, the latches, the timeout counter and the steering muxes.

Verification
REQ-036 Single request: req_rd[0]=1, req_lba slice0=32'h0000_0240 -> sd_rd=1 next cycle with sd_lba=32'h240. Host pulses sd_ack high for 512 cycles -> req_ack[0] mirrors it. Then busy=0 two cycles after sd_ack falls.
REQ-037 Simultaneous requests: req_rd=2'b11 held, four transfers -> grants 0,1,0,1. Requester 1 never sees req_ack or req_buff_wr during requester 0's transfers.
REQ-038 Both directions: req_rd[1]=req_wr[1]=1 -> sd_wr=1, sd_rd=0. sd_buff_din equals req_buff_din slice1 throughout XFER.
REQ-039 Timeout with TIMEOUT=100: no sd_ack -> sd_rd falls after 100 ISSUE cycles, req_err[0] pulses once, busy=0 two cycles later.
REQ-040 Reset mid-transfer: reset asserted during XFER with sd_ack=1 -> sd_rd=0, req_ack=0 and busy=0 in the same cycle. After release the first grant goes to index 0.
